// File: rtl/kbd_fifo.sv
// kbd_fifo
// ---------------------------------------------------------------------------
// Scan-code buffer between the PS/2 keyboard receiver and the CPU port space.
// Every received byte (kdone/kdata) is pushed into a circular FIFO so that no
// keystrokes are lost while the CPU is busy. The CPU drains the FIFO through a
// data port (PORT_BASE) and controls it through a status/control port
// (PORT_BASE+1). A level interrupt is raised while data is pending and the
// interrupt is enabled.
//
// Parameters
//   DEPTH     : FIFO entries, power of two, 2..256
//   AW        : pointer width, log2(DEPTH)
//   PORT_BASE : data port number; status/control port is PORT_BASE+1
//   FILTER    : 1 = drop PS/2 break sequences (0xF0 and the byte after it)
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   kdone        in   one-cycle strobe, new scan code on kdata
//   kdata        in   [7:0] received scan code
//   address      in   [7:0] CPU port number
//   port_rd      in   one-cycle CPU port-read strobe
//   port_we      in   one-cycle CPU port-write strobe
//   out          in   [7:0] CPU write data
//   dout         out  [7:0] port read data (combinational)
//   irq          out  interrupt request, level
//   count        out  [AW:0] current fill level, 0..DEPTH
//   filter_state out  break-filter FSM state (0 = IDLE, 1 = SKIP)
//
// Handshake: kdone, port_rd and port_we are single-cycle strobes with no
// back-pressure; each high cycle is one event and is acted on at the next
// rising clock edge. dout is valid in the same cycle as address/port_rd.
//
// Status byte (PORT_BASE+1) = {count[4:0] (saturated at 31), ovf, ien, ne}
// Control write (PORT_BASE+1): bit0 -> ien, bit1 = flush, bit2 = clear ovf
// ---------------------------------------------------------------------------
module kbd_fifo #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] PORT_BASE = 8'h40,
  parameter bit         FILTER    = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          kdone,
  input  logic [7:0]    kdata,
  input  logic [7:0]    address,
  input  logic          port_rd,
  input  logic          port_we,
  input  logic [7:0]    out,
  output logic [7:0]    dout,
  output logic          irq,
  output logic [AW:0]   count,
  output logic          filter_state
);

  localparam logic [7:0] STAT_PORT = PORT_BASE + 8'd1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [7:0]  BREAK_CODE = 8'hF0;

  // -------------------------------------------------------------------------
  // Storage and pointer state
  // -------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          ovf;
  logic          ien;

  // -------------------------------------------------------------------------
  // Decoded port events
  // -------------------------------------------------------------------------
  logic ctrl_we;
  logic flush;
  logic ovf_clr;
  logic not_empty;
  logic pop;
  logic pass;
  logic push_req;
  logic push;
  logic ovf_set;

  assign not_empty = (count != '0);
  assign ctrl_we   = port_we && (address == STAT_PORT);
  assign flush     = ctrl_we && out[1];
  assign ovf_clr   = ctrl_we && out[2];

  // A pop on an empty FIFO is simply ignored.
  assign pop       = port_rd && (address == PORT_BASE) && not_empty;

  assign push_req  = kdone && pass;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push      = push_req && ((count < CNT_FULL) || pop);
  // Flush discards the incoming byte without treating it as an overflow.
  assign ovf_set   = push_req && !push && !flush;

  // Bits 7:3 of the control byte are reserved.
  logic unused_out;
  assign unused_out = ^out[7:3];

  // -------------------------------------------------------------------------
  // Break-code filter FSM (three processes)
  // -------------------------------------------------------------------------
  typedef enum logic {
    F_IDLE = 1'b0,
    F_SKIP = 1'b1
  } filt_t;

  filt_t fstate;
  filt_t fstate_nxt;

  // State register: flush returns the filter to IDLE, same as reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      fstate <= F_IDLE;
    end else begin
      fstate <= fstate_nxt;
    end
  end

  // Next state: only moves when filtering is compiled in.
  always_comb begin
    fstate_nxt = fstate;
    if (FILTER && kdone) begin
      case (fstate)
        F_IDLE:  if (kdata == BREAK_CODE) fstate_nxt = F_SKIP;
        F_SKIP:  fstate_nxt = F_IDLE;
        default: fstate_nxt = F_IDLE;
      endcase
    end
  end

  // Outputs: pass qualifies the current kdata byte for storage.
  always_comb begin
    pass         = 1'b1;
    filter_state = fstate;
    if (FILTER) begin
      case (fstate)
        F_IDLE:  pass = (kdata != BREAK_CODE);
        F_SKIP:  pass = 1'b0;
        default: pass = 1'b1;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Data memory (not reset; contents are only read behind count != 0)
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      mem[wptr] <= kdata;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers and fill level
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Overflow flag and interrupt enable
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf <= 1'b0;
      ien <= 1'b0;
    end else begin
      // Set has priority over a clear in the same cycle.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (ctrl_we) begin
        ien <= out[0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  logic [8:0] count_wide;
  logic [4:0] count_field;
  logic [7:0] status;

  assign count_wide  = 9'(count);
  // Only five bits fit in the status byte; deeper FIFOs saturate at 31.
  assign count_field = (count_wide > 9'd31) ? 5'd31 : count_wide[4:0];
  assign status      = {count_field, ovf, ien, not_empty};

  always_comb begin
    dout = 8'h00;
    if (address == PORT_BASE) begin
      dout = not_empty ? mem[rptr] : 8'h00;
    end else if (address == STAT_PORT) begin
      dout = status;
    end
  end

  assign irq = ien && not_empty;

endmodule
